// File: rtl/regbus_pkg.sv
// rtl/regbus_pkg.sv - shared request codes, FSM states and default sizes for the register bus
package regbus_pkg;

    localparam int NREGS_DEF = 16;
    localparam int DW_DEF    = 4;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef enum logic [3:0] {
        REQ_IDLE  = 4'b0000,
        REQ_READ  = 4'b0001,
        REQ_WRITE = 4'b0010,
        REQ_NEXT  = 4'b0011
    } req_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_SEL,
        S_ACK
    } state_e;

endpackage

// File: rtl/regfile16.sv
// rtl/regfile16.sv - register array with synchronous write, combinational read, synchronous clear
module regfile16 #(
    parameter int NREGS = 16,
    parameter int DW    = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [NREGS];

    // Reset wins over a same-edge write so an interrupted WRITE never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/regbus_responder.sv
// rtl/regbus_responder.sv - 4-phase BUSREQ responder holding the core's register file
module regbus_responder
    import regbus_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    busreq,
    input  logic [DW-1:0] core_data,
    input  logic [AW-1:0] sel_in,
    input  logic          sel_valid,
    output logic [DW-1:0] bus_data,
    output logic [AW-1:0] opnd,
    output logic          ack,
    output logic          err
);

    state_e        state, state_nx;
    logic [3:0]    req_q, req_nx;
    logic [AW-1:0] cur_sel, cur_sel_nx, opnd_nx;
    logic [DW-1:0] bus_data_nx, rdata;
    logic          ack_nx, err_nx, we;

    regfile16 #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (cur_sel),
        .wdata (core_data),
        .raddr (cur_sel),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            req_q    <= REQ_IDLE;
            cur_sel  <= '0;
            opnd     <= '0;
            bus_data <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            req_q    <= req_nx;
            cur_sel  <= cur_sel_nx;
            opnd     <= opnd_nx;
            bus_data <= bus_data_nx;
            ack      <= ack_nx;
            err      <= err_nx;
        end
    end

    // Operations act on the latched req_q; busreq only matters in IDLE and ACK.
    always_comb begin
        state_nx    = state;
        req_nx      = req_q;
        cur_sel_nx  = cur_sel;
        opnd_nx     = opnd;
        bus_data_nx = bus_data;
        ack_nx      = ack;
        err_nx      = err;
        we          = 1'b0;
        case (state)
            S_IDLE: begin
                if (busreq != REQ_IDLE) begin
                    req_nx   = busreq;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                case (req_q)
                    REQ_READ: begin
                        bus_data_nx = rdata;
                        ack_nx      = 1'b1;
                        state_nx    = S_ACK;
                    end
                    REQ_WRITE: begin
                        we       = 1'b1;
                        ack_nx   = 1'b1;
                        state_nx = S_ACK;
                    end
                    REQ_NEXT: begin
                        if (sel_valid) begin
                            cur_sel_nx = sel_in;
                            opnd_nx    = sel_in;
                            ack_nx     = 1'b1;
                            state_nx   = S_ACK;
                        end else begin
                            state_nx = S_WAIT_SEL;
                        end
                    end
                    default: begin
                        bus_data_nx = '0;
                        err_nx      = 1'b1;
                        ack_nx      = 1'b1;
                        state_nx    = S_ACK;
                    end
                endcase
            end
            S_WAIT_SEL: begin
                if (sel_valid) begin
                    cur_sel_nx = sel_in;
                    opnd_nx    = sel_in;
                    ack_nx     = 1'b1;
                    state_nx   = S_ACK;
                end
            end
            S_ACK: begin
                if (busreq == REQ_IDLE) begin
                    ack_nx   = 1'b0;
                    state_nx = S_IDLE;
                end else if (busreq != req_q) begin
                    err_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regbus_responder.sv
// tb/tb_regbus_responder.sv - randomized self-checking bench for regbus_responder
module tb_regbus_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] busreq;
    logic [3:0] core_data;
    logic [3:0] sel_in;
    logic       sel_valid;
    logic [3:0] bus_data;
    logic [3:0] opnd;
    logic       ack;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_regs [16];
    logic [3:0] m_sel, m_bus;
    logic       m_err;

    regbus_responder #(.NREGS(16), .DW(4), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .busreq    (busreq),
        .core_data (core_data),
        .sel_in    (sel_in),
        .sel_valid (sel_valid),
        .bus_data  (bus_data),
        .opnd      (opnd),
        .ack       (ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 4'd0;
        m_sel = 4'd0;
        m_bus = 4'd0;
        m_err = 1'b0;
    endtask

    task automatic model_apply(input logic [3:0] code, input logic [3:0] sel, input logic [3:0] data);
        case (code)
            4'd1: m_bus = m_regs[m_sel];
            4'd2: m_regs[m_sel] = data;
            4'd3: m_sel = sel;
            default: begin
                m_bus = 4'd0;
                m_err = 1'b1;
            end
        endcase
    endtask

    // Cycles from driving a request to seeing ack: 2, or one past the last low sel_valid edge for NEXT.
    function automatic int exp_lat(input logic [3:0] code, input int stall);
        if (code == 4'd3 && stall + 1 > 2) return stall + 1;
        return 2;
    endfunction

    task automatic do_reset();
        rst = 1'b1; busreq = 4'd0; sel_valid = 1'b0; sel_in = 4'd0; core_data = 4'd0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
    endtask

    // Full 4-phase handshake; sel_valid is held low for the first `stall` edges.
    task automatic bus_txn(input logic [3:0] code, input logic [3:0] sel, input logic [3:0] data,
                           input int stall, output int lat, output logic [3:0] bd,
                           output logic [3:0] op, output logic e, output logic ack_after);
        bit done = 0;
        busreq = code; sel_in = sel; core_data = data; sel_valid = (stall == 0);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack) done = 1;
            else if (lat >= stall) sel_valid = 1'b1;
        end
        bd = bus_data; op = opnd; e = err;
        busreq = 4'd0; sel_valid = 1'b0;
        @(posedge clk); #1;
        ack_after = ack;
    endtask

    task automatic test_reset();
        int lat; logic [3:0] bd, op; logic e, aa;
        rst = 1'b1; busreq = 4'b0011; sel_in = 4'd5; sel_valid = 1'b1; core_data = 4'd0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (opnd !== 4'd0) begin errors++; $display("FAIL reset_opnd got=%0d exp=0", opnd); end
        checks++; if (bus_data !== 4'd0) begin errors++; $display("FAIL reset_bus_data got=%0d exp=0", bus_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0; busreq = 4'd0; sel_valid = 1'b0;
        model_reset();
        bus_txn(4'd1, 4'd0, 4'd0, 0, lat, bd, op, e, aa);
        checks++; if (bd !== 4'd0) begin errors++; $display("FAIL reset_read got=%0d exp=0", bd); end
        checks++; if (lat != 2) begin errors++; $display("FAIL reset_read_lat got=%0d exp=2", lat); end
    endtask

    task automatic test_next();
        int lat; logic [3:0] bd, op; logic e, aa;
        do_reset();
        bus_txn(4'd3, 4'd1, 4'd0, 0, lat, bd, op, e, aa);
        checks++; if (lat != 2) begin errors++; $display("FAIL next_lat got=%0d exp=2", lat); end
        checks++; if (op !== 4'd1) begin errors++; $display("FAIL next_opnd got=%0d exp=1", op); end
        checks++; if (aa !== 1'b0) begin errors++; $display("FAIL next_ack_drop got=%b exp=0", aa); end
    endtask

    task automatic test_write_read();
        int lat; logic [3:0] bd, op; logic e, aa;
        do_reset();
        bus_txn(4'd3, 4'd1, 4'd0, 0, lat, bd, op, e, aa);
        bus_txn(4'd2, 4'd0, 4'd7, 0, lat, bd, op, e, aa);
        checks++; if (lat != 2) begin errors++; $display("FAIL write_lat got=%0d exp=2", lat); end
        bus_txn(4'd1, 4'd0, 4'd0, 0, lat, bd, op, e, aa);
        checks++; if (bd !== 4'd7) begin errors++; $display("FAIL read_back got=%0d exp=7", bd); end
        bus_txn(4'd3, 4'd2, 4'd0, 0, lat, bd, op, e, aa);
        bus_txn(4'd1, 4'd0, 4'd0, 0, lat, bd, op, e, aa);
        checks++; if (bd !== 4'd0) begin errors++; $display("FAIL read_other got=%0d exp=0", bd); end
        checks++; if (op !== 4'd2) begin errors++; $display("FAIL opnd_hold got=%0d exp=2", op); end
    endtask

    task automatic test_stall();
        int lat; logic [3:0] bd, op; logic e, aa;
        do_reset();
        bus_txn(4'd3, 4'd3, 4'd0, 5, lat, bd, op, e, aa);
        checks++; if (lat != 6) begin errors++; $display("FAIL stall_lat got=%0d exp=6", lat); end
        checks++; if (op !== 4'd3) begin errors++; $display("FAIL stall_opnd got=%0d exp=3", op); end
    endtask

    task automatic test_bad_code();
        int lat; logic [3:0] bd, op; logic e, aa;
        do_reset();
        bus_txn(4'd3, 4'd4, 4'd0, 0, lat, bd, op, e, aa);
        bus_txn(4'd2, 4'd0, 4'd5, 0, lat, bd, op, e, aa);
        bus_txn(4'd1, 4'd0, 4'd0, 0, lat, bd, op, e, aa);
        bus_txn(4'b1010, 4'd0, 4'd0, 0, lat, bd, op, e, aa);
        checks++; if (lat != 2) begin errors++; $display("FAIL bad_lat got=%0d exp=2", lat); end
        checks++; if (bd !== 4'd0) begin errors++; $display("FAIL bad_bus_data got=%0d exp=0", bd); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_err got=%b exp=1", e); end
        bus_txn(4'd1, 4'd0, 4'd0, 0, lat, bd, op, e, aa);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", e); end
        checks++; if (bd !== 4'd5) begin errors++; $display("FAIL read_after_bad got=%0d exp=5", bd); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err); end
    endtask

    task automatic test_protocol_violation();
        int lat; logic [3:0] bd, op; logic e, aa;
        int n;
        do_reset();
        bus_txn(4'd3, 4'd4, 4'd0, 0, lat, bd, op, e, aa);
        busreq = 4'd1;
        n = 0;
        while (!ack && n < 10) begin @(posedge clk); #1; n++; end
        busreq = 4'd2; core_data = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL viol_ack_hold got=%b exp=1", ack); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL viol_err got=%b exp=1", err); end
        busreq = 4'd0;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL viol_ack_drop got=%b exp=0", ack); end
        bus_txn(4'd1, 4'd0, 4'd0, 0, lat, bd, op, e, aa);
        checks++; if (bd !== 4'd0) begin errors++; $display("FAIL viol_no_write got=%0d exp=0", bd); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [3:0] bd, op; logic e, aa;
        bit ack_seen = 0;
        do_reset();
        bus_txn(4'd3, 4'd2, 4'd0, 0, lat, bd, op, e, aa);
        busreq = 4'd2; core_data = 4'd9;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        if (ack) ack_seen = 1;
        rst = 1'b0; busreq = 4'd0;
        repeat (3) begin @(posedge clk); #1; if (ack) ack_seen = 1; end
        checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL midop_ack got=%b exp=0", ack_seen); end
        model_reset();
        bus_txn(4'd3, 4'd2, 4'd0, 0, lat, bd, op, e, aa);
        bus_txn(4'd1, 4'd0, 4'd0, 0, lat, bd, op, e, aa);
        checks++; if (bd !== 4'd0) begin errors++; $display("FAIL midop_read got=%0d exp=0", bd); end
    endtask

    task automatic test_random();
        int lat, stall, r;
        logic [3:0] bd, op, code, sel, data;
        logic e, aa;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) code = 4'd1;
            else if (r < 6) code = 4'd2;
            else if (r < 9) code = 4'd3;
            else code = 4'($urandom_range(4, 15));
            sel   = 4'($urandom_range(0, 15));
            data  = 4'($urandom_range(0, 15));
            stall = $urandom_range(0, 4);
            bus_txn(code, sel, data, stall, lat, bd, op, e, aa);
            model_apply(code, sel, data);
            checks++; if (lat != exp_lat(code, stall)) begin errors++; $display("FAIL rnd_lat[%0d] code=%0d got=%0d exp=%0d", i, code, lat, exp_lat(code, stall)); end
            checks++; if (bd !== m_bus) begin errors++; $display("FAIL rnd_bus_data[%0d] code=%0d got=%0d exp=%0d", i, code, bd, m_bus); end
            checks++; if (op !== m_sel) begin errors++; $display("FAIL rnd_opnd[%0d] got=%0d exp=%0d", i, op, m_sel); end
            checks++; if (e !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", i, e, m_err); end
            checks++; if (aa !== 1'b0) begin errors++; $display("FAIL rnd_ack_drop[%0d] got=%b exp=0", i, aa); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_next();
        test_write_read();
        test_stall();
        test_bad_code();
        test_protocol_violation();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
